// File: rtl/fanout_checker.sv
// Fanout tree checker: compares every leaf of a fanout tree against its source
// for a programmable number of cycles and reports a saturating error count and per-leaf mask.
module fanout_checker #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       num_cycles,
  input  logic             din,
  input  logic [WIDTH-1:0] fan_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIDTH-1:0] err_mask
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             clear;
  logic             s1_valid_q;
  logic             s1_din_q;
  logic [WIDTH-1:0] s1_fan_q;
  logic [WIDTH-1:0] mism;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clear   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          clear = 1'b1;
          if (num_cycles != 8'd0) begin
            state_d = StRun;
            cnt_d   = num_cycles;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRun: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = StDrain;
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
    pass = (err_cnt == '0);
  end

  // Stage 1: capture the sample taken in each RUN cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_din_q   <= 1'b0;
      s1_fan_q   <= '0;
    end else begin
      s1_valid_q <= (state_q == StRun);
      s1_din_q   <= din;
      s1_fan_q   <= fan_in;
    end
  end

  assign mism = s1_fan_q ^ {WIDTH{s1_din_q}};

  // Stage 2: accumulate; a fresh start clears ahead of any pending update.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt  <= '0;
      err_mask <= '0;
    end else if (clear) begin
      err_cnt  <= '0;
      err_mask <= '0;
    end else if (s1_valid_q) begin
      err_mask <= err_mask | mism;
      if ((|mism) && (err_cnt != {CNT_W{1'b1}})) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fanout_checker.sv
// Randomized directed bench for fanout_checker: a wide-counter and a 2-bit-counter
// instance share stimulus and are compared against a per-run behavioural model.
module tb_fanout_checker;
  localparam int unsigned WIDTH = 20;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [7:0]       num_cycles = 8'd0;
  logic             din = 1'b0;
  logic [WIDTH-1:0] fan_in = '0;
  logic             busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [15:0]      err_cnt_a;
  logic [1:0]       err_cnt_b;
  logic [WIDTH-1:0] err_mask_a, err_mask_b;

  int vectors = 0;
  int errs = 0;

  fanout_checker #(.WIDTH(WIDTH), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .start(start), .num_cycles(num_cycles), .din(din),
    .fan_in(fan_in), .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_cnt_a),
    .err_mask(err_mask_a)
  );

  fanout_checker #(.WIDTH(WIDTH), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .start(start), .num_cycles(num_cycles), .din(din),
    .fan_in(fan_in), .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_cnt_b),
    .err_mask(err_mask_b)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy_a"}, {31'd0, busy_a}, 32'd0);
    chk({tag, "_busy_b"}, {31'd0, busy_b}, 32'd0);
    chk({tag, "_done_a"}, {31'd0, done_a}, 32'd0);
    chk({tag, "_done_b"}, {31'd0, done_b}, 32'd0);
  endtask

  task automatic chk_results(input string tag, input int cnt, input logic [WIDTH-1:0] mask);
    int sat;
    sat = (cnt > 3) ? 3 : cnt;
    chk({tag, "_cnt_a"}, err_cnt_a, cnt);
    chk({tag, "_cnt_b"}, {30'd0, err_cnt_b}, sat);
    chk({tag, "_mask_a"}, {12'd0, err_mask_a}, {12'd0, mask});
    chk({tag, "_mask_b"}, {12'd0, err_mask_b}, {12'd0, mask});
    chk({tag, "_pass_a"}, {31'd0, pass_a}, {31'd0, cnt == 0});
    chk({tag, "_pass_b"}, {31'd0, pass_b}, {31'd0, cnt == 0});
  endtask

  // mode 0: clean, toggling din; 1: leaf 5 stuck low; 2: all leaves inverted; 3: sparse faults
  task automatic run(input int n, input int mode, input int restart_at);
    logic [WIDTH-1:0] mask, f, flip;
    logic             d;
    int               cnt;
    mask = '0;
    cnt  = 0;
    start = 1'b1;
    num_cycles = 8'(n);
    step();
    start = 1'b0;
    if (n != 0) begin
      chk("entry_busy", {31'd0, busy_a}, 32'd1);
      chk_results("entry_clear", 0, '0);
      for (int k = 0; k < n; k++) begin
        flip = '0;
        if ($urandom_range(0, 3) == 0) flip[$urandom_range(0, WIDTH - 1)] = 1'b1;
        case (mode)
          0:       begin d = k[0];            f = {WIDTH{d}}; end
          1:       begin d = k[0];            f = {WIDTH{d}}; f[5] = 1'b0; end
          2:       begin d = 1'($urandom());  f = ~{WIDTH{d}}; end
          default: begin d = 1'($urandom());  f = {WIDTH{d}} ^ flip; end
        endcase
        din = d;
        fan_in = f;
        start = (k == restart_at);
        num_cycles = 8'($urandom_range(1, 255));
        if ((f ^ {WIDTH{d}}) != '0) cnt++;
        mask |= f ^ {WIDTH{d}};
        chk("run_busy", {31'd0, busy_b}, 32'd1);
        chk("run_done", {31'd0, done_a}, 32'd0);
        step();
      end
      start = 1'b0;
      din = 1'($urandom());
      fan_in = WIDTH'($urandom());
      chk("drain_busy", {31'd0, busy_a}, 32'd1);
      chk("drain_done", {31'd0, done_a}, 32'd0);
      step();
      din = 1'($urandom());
      fan_in = WIDTH'($urandom());
    end
    chk("done_a", {31'd0, done_a}, 32'd1);
    chk("done_b", {31'd0, done_b}, 32'd1);
    chk("done_busy", {31'd0, busy_a}, 32'd1);
    chk_results("done", cnt, mask);
    step();
    chk_idle_outputs("after_done");
    chk_results("held", cnt, mask);
  endtask

  initial begin
    start = 1'b1;
    num_cycles = 8'd5;
    step();
    step();
    chk_idle_outputs("reset");
    chk_results("reset", 0, '0);
    reset = 1'b0;
    start = 1'b0;

    run(10, 0, -1);
    run(8, 1, -1);
    run(0, 0, -1);
    run(6, 2, -1);
    run(0, 0, -1);
    run(9, 3, 3);

    // Abort mid-run with reset: no done pulse may follow.
    start = 1'b1;
    num_cycles = 8'd10;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      din = 1'($urandom());
      fan_in = ~{WIDTH{din}};
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_idle_outputs("abort");
    chk_results("abort", 0, '0);
    for (int k = 0; k < 14; k++) begin
      chk("abort_no_done", {31'd0, done_a | done_b}, 32'd0);
      step();
    end

    run(7, 2, -1);
    for (int r = 0; r < 10; r++) run(int'($urandom_range(0, 12)), int'($urandom_range(2, 3)), -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
